// File: rtl/dev_mem_sram_ctrl.sv
// dev_mem responder: turns MMU word requests into timed async-SRAM cycles.
// Optional DEV_MEM_WR_FORWARD_EN: written word is forwarded as read data.
module dev_mem_sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              mem_we_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_busy_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        dq_q, dq_d;
  logic               ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic               ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [ADDR_W-1:0]  req_addr;
  logic               start;
  logic               unused_addr;

  // addr_q doubles as the last-accessed address for the hit check
  assign req_addr    = mem_addr_i[ADDR_W+1:2];
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};
  assign start       = (state_q == IDLE) &
                       (mem_we_i | ~valid_q | (req_addr != addr_q));
  assign mem_busy_o  = (state_q != IDLE) | start;

  assign mem_rdata_o = rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = dq_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_oe  = dq_oe_q;

  // Next-state, datapath latches and strobes (decoded from next state)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    dq_d    = dq_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = req_addr;
          if (mem_we_i) begin
            dq_d    = mem_wdata_i;
            state_d = WR_SETUP;
          end else begin
            cnt_d   = CNT_W'(RD_WAIT - 1);
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d = sram_dq_i;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        cnt_d   = CNT_W'(WR_WAIT - 1);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else state_d = WR_HOLD;
      end
      WR_HOLD: begin
`ifdef DEV_MEM_WR_FORWARD_EN
        rdata_d = dq_q;
        valid_d = 1'b1;
`else
        valid_d = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR_PULSE);
    dq_oe_d = (state_d == WR_SETUP) | (state_d == WR_PULSE) |
              (state_d == WR_HOLD);
  end

  // State and registered strobes; reset drops strobes immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      dq_q    <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      dq_q    <= dq_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

endmodule
